shift_mix_add_stage: RTL and testbench
======================================

# shift_mix_add_stage

Round-tail stage of the hardware AES encryption datapath, sitting directly downstream of the 16-way S-box SubBytes stage. It accepts the substituted 128-bit state with its round number and round key, applies ShiftRows, MixColumns (skipped on round 10), and AddRoundKey, then presents the registered result to the round controller. Both the input and output sides use valid/ready handshakes, so the stage can stall without losing data.

## Interface
- Parameters: none (AES-128 only; 10 rounds fixed).
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_state  in  128  post-SubBytes state; byte 0 = [127:120], byte i is row i%4, column i/4
- in_round  in  4  round number, 1..10
- in_key  in  128  round key for in_round, same byte order
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_state  out  128  round output state
- out_round  out  4  echo of in_round
- out_last  out  1  out_round == 10
- out_err  out  1  in_round was 0 or >10; out_state is then still computed, as a non-final round

## Operation
- ShiftRows: row r rotates left by r bytes. Output byte (r,c) = input byte (r,(c+r) mod 4).
- MixColumns, per column: s'0=2a0^3a1^a2^a3, s'1=a0^2a1^3a2^a3, s'2=a0^a1^2a2^3a3, s'3=3a0^a1^a2^2a3.
- xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00), all in 8-bit arithmetic.
- Round 10: MixColumns is bypassed. Result = ShiftRows(in_state) ^ in_key.
- Rounds 1..9 and error rounds: result = MixColumns(ShiftRows(in_state)) ^ in_key.
- Transfer happens when valid && ready on the same edge.
- in_ready = !out_valid || out_ready. This is combinational and gives back-to-back throughput of one beat per cycle.
- Holding: while out_valid && !out_ready, out_state, out_round, out_last, and out_err hold stable.
- Simultaneous output drain and new input on one edge: the new beat replaces the old one and out_valid stays 1.
- The stage must not depend on in_state or in_key being stable after the accepting edge.

## Timing
- Reset (async assert, sync deassert by the system):
  - out_valid=0, out_state=0, out_round=0, out_last=0, out_err=0.
  - in_ready reads 1 while in reset.
- Latency: one cycle from accepting edge to out_valid=1 with the result. No combinational path from in_* to out_*.
- Reset mid-operation: any held or in-flight beat is discarded. No output is produced for it after release.
- Data outputs update only on accepted edges. out_valid falls only on a drain without a new accept.

## Configuration
- SMA_PIPE_EN:
  - Defined: the stage is split into two registers. Stage A holds ShiftRows+MixColumns/bypass plus key, round, and flags. Stage B holds the result after AddRoundKey.
    - Latency is 2 cycles and throughput remains 1 beat/cycle.
    - Each stage has its own valid bit and advances when the next stage is empty or draining.
    - in_ready = !A_valid || (!B_valid || out_ready).
    - Both valids reset to 0.
  - Undefined: single-register behaviour as above, with latency 1.

## Test plan
- FIPS-197 round 1 → out_state a49c7ff2689f352b6b5bea43026a5049, out_last=0, out_err=0, one cycle later (two with SMA_PIPE_EN).
  - in_state d42711aee0bf98f1b8b45de51e415230
  - in_round 1
  - in_key a0fafe1788542cb123a339392a6c7605
- Final round → out_state 3925841d02dc09fbdc118597196a0b32, out_last=1.
  - in_state e9098972cb31075f3d327d94af2e2cb5
  - in_round 10
  - in_key d014f9a8c9ee2589e13f0cc8b6630ca6
- Backpressure: hold out_ready=0 for 5 cycles after the round-1 result.
  - Required: out_* stable, in_ready=0, a second offered beat is not consumed.
  - Then raise out_ready: the second beat appears the next cycle.
- Streaming: 10 consecutive beats with out_ready=1 → 10 results on consecutive cycles, in order, no bubbles.
- Error round: in_round 0, then 11 → out_err=1, out_last=0, and out_state equals the full-round computation.
- Reset mid-stall: assert reset_n=0 while out_valid=1 → out_valid drops immediately; after release there is no stale output, and the next accepted beat is correct.

Source files
------------

// File: rtl/shift_mix_add_stage_if.sv
// shift_mix_add_stage_if
// Handshake bundle for the AES round-tail stage. It carries both sides of the
// stage: the input beat (post-SubBytes state, round number and round key) and
// the registered result (round output state, round echo and flags).
//
// Signals:
//   in_valid   input beat present                  (master -> slave)
//   in_ready   stage can accept a beat this cycle  (slave -> master)
//   in_state   128-bit post-SubBytes state, byte 0 = [127:120]
//   in_round   round number, 1..10 legal
//   in_key     128-bit round key, same byte order as in_state
//   out_valid  result present                      (slave -> master)
//   out_ready  consumer accepts result             (master -> slave)
//   out_state  128-bit round output state
//   out_round  echo of in_round
//   out_last   result belongs to round 10
//   out_err    round number was 0 or above 10
//
// Modports:
//   master  producer/consumer side (the round controller or a testbench)
//   slave   the shift_mix_add_stage itself
interface shift_mix_add_stage_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [3:0]   in_round;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;
    logic         out_err;

    modport master (
        output in_valid, in_state, in_round, in_key, out_ready,
        input  in_ready, out_valid, out_state, out_round, out_last, out_err
    );

    modport slave (
        input  in_valid, in_state, in_round, in_key, out_ready,
        output in_ready, out_valid, out_state, out_round, out_last, out_err
    );
endinterface

// File: rtl/shift_mix_add_stage.sv
// shift_mix_add_stage
// Round-tail stage of the AES-128 encryption datapath. It takes the state
// coming out of SubBytes, applies ShiftRows, MixColumns (bypassed in round 10)
// and AddRoundKey, and hands the registered result to the round controller.
// Both sides use valid/ready, so the stage stalls without losing a beat.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous, active-low reset
//   bus      shift_mix_add_stage_if.slave (input beat and registered result)
//
// Configuration:
//   SMA_PIPE_EN  when defined, the stage is split into two registers
//                (A: ShiftRows + MixColumns/bypass with key and flags,
//                 B: result after AddRoundKey), giving 2-cycle latency at
//                one beat per cycle. When undefined, a single output
//                register gives 1-cycle latency.
module shift_mix_add_stage (
    input  logic                  clk,
    input  logic                  reset_n,
    shift_mix_add_stage_if.slave  bus
);

    // GF(2^8) multiply by 2 with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (row, col) sits at index 4*col+row, counted from the MSB end.
    // Row r rotates left by r, so output (r,c) takes input (r,(c+r) mod 4).
    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return res;
    endfunction

    // One column is four contiguous bytes, a0 in the top byte. 3*a is
    // written as xtime(a)^a.
    function automatic logic [31:0] mixColumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic         isFinal;
    logic         isErr;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic         inReady;
    logic         accept;

    // Error rounds (0 or >10) are still processed as ordinary full rounds;
    // only round 10 skips MixColumns.
    assign isFinal = (bus.in_round == 4'd10);
    assign isErr   = (bus.in_round == 4'd0) || (bus.in_round > 4'd10);
    assign shifted = shiftRows(bus.in_state);

    always_comb begin
        mixed = shifted;
        if (!isFinal) begin
            for (int c = 0; c < 4; c++) begin
                mixed[127 - 32*c -: 32] = mixColumn(shifted[127 - 32*c -: 32]);
            end
        end
    end

    // Output register (stage B when pipelined).
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_state_q, out_state_d;
    logic [3:0]   out_round_q, out_round_d;
    logic         out_last_q,  out_last_d;
    logic         out_err_q,   out_err_d;

`ifdef SMA_PIPE_EN
    // Stage A keeps the key unapplied so AddRoundKey lands in stage B.
    logic         a_valid_q, a_valid_d;
    logic [127:0] a_mixed_q, a_mixed_d;
    logic [127:0] a_key_q,   a_key_d;
    logic [3:0]   a_round_q, a_round_d;
    logic         a_last_q,  a_last_d;
    logic         a_err_q,   a_err_d;
    logic         bAdvance;

    // Each register moves when the one downstream of it is empty or
    // draining this cycle. Data registers change only on a transfer.
    always_comb begin
        bAdvance = !out_valid_q || bus.out_ready;
        inReady  = !a_valid_q || bAdvance;
        accept   = bus.in_valid && inReady;

        a_valid_d = a_valid_q;
        a_mixed_d = a_mixed_q;
        a_key_d   = a_key_q;
        a_round_d = a_round_q;
        a_last_d  = a_last_q;
        a_err_d   = a_err_q;
        if (inReady) begin
            a_valid_d = bus.in_valid;
            if (accept) begin
                a_mixed_d = mixed;
                a_key_d   = bus.in_key;
                a_round_d = bus.in_round;
                a_last_d  = isFinal;
                a_err_d   = isErr;
            end
        end

        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        if (bAdvance) begin
            out_valid_d = a_valid_q;
            if (a_valid_q) begin
                out_state_d = a_mixed_q ^ a_key_q;
                out_round_d = a_round_q;
                out_last_d  = a_last_q;
                out_err_d   = a_err_q;
            end
        end
    end

    // Both stages reset empty; any in-flight beat is dropped on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_valid_q   <= 1'b0;
            a_mixed_q   <= '0;
            a_key_q     <= '0;
            a_round_q   <= '0;
            a_last_q    <= 1'b0;
            a_err_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_mixed_q   <= a_mixed_d;
            a_key_q     <= a_key_d;
            a_round_q   <= a_round_d;
            a_last_q    <= a_last_d;
            a_err_q     <= a_err_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
        end
    end
`else
    // A new beat may replace a draining one on the same edge; valid falls
    // only when the result drains with nothing new arriving.
    always_comb begin
        inReady = !out_valid_q || bus.out_ready;
        accept  = bus.in_valid && inReady;

        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_state_d = mixed ^ bus.in_key;
            out_round_d = bus.in_round;
            out_last_d  = isFinal;
            out_err_d   = isErr;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Reset clears the held result so nothing stale reappears after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
        end
    end
`endif

    assign bus.in_ready  = inReady;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;
    assign bus.out_round = out_round_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_shift_mix_add_stage.sv
// tb_shift_mix_add_stage
// Directed and randomized bench for shift_mix_add_stage. Expected results come
// from a byte-array AES round model with a generic GF(2^8) multiplier, plus
// the FIPS-197 vectors for rounds 1 and 10.
//
// Ports: none (top-level bench). Honours SMA_PIPE_EN for the expected latency.
module tb_shift_mix_add_stage;

`ifdef SMA_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    shift_mix_add_stage_if bus ();

    shift_mix_add_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] a;
        logic [7:0] b;
        logic       hi;
        p = 8'h00;
        a = x;
        b = y;
        for (int i = 0; i < 8; i++) begin
            if (a[0]) p = p ^ b;
            hi = b[7];
            b  = {b[6:0], 1'b0};
            if (hi) b = b ^ 8'h1b;
            a = a >> 1;
        end
        return p;
    endfunction

    // Reference AES round tail on explicit byte arrays.
    function automatic logic [127:0] refRound(input logic [127:0] s, input logic [3:0] rnd,
                                              input logic [127:0] k);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   m [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = s[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c + r] = a[4*((c + r) % 4) + r];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[4*c + r] = (rnd == 4'd10) ? b[4*c + r] :
                             gmul(8'd2, b[4*c + r]) ^ gmul(8'd3, b[4*c + (r + 1) % 4]) ^
                             b[4*c + (r + 2) % 4] ^ b[4*c + (r + 3) % 4];
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = m[i] ^ k[127 - 8*i -: 8];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat, wait the pipeline latency, then check the result.
    // The caller chooses out_ready; the result is left in place.
    task automatic applyStimulus(input string tag, input logic [127:0] s, input logic [3:0] rnd,
                                 input logic [127:0] k, input logic [127:0] expState);
        bus.in_valid = 1'b1;
        bus.in_state = s;
        bus.in_round = rnd;
        bus.in_key   = k;
        #1;
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
        for (int n = 0; n < LAT; n++) begin
            cyc();
            bus.in_valid = 1'b0;
            bus.in_state = {$urandom, $urandom, $urandom, $urandom};
            bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
            if (n < LAT - 1) chk({tag, "_early_valid"}, bus.out_valid, 1'b0);
        end
        checkOutput(tag, expState, rnd);
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] expState, input logic [3:0] rnd);
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_state"}, bus.out_state, expState);
        chk({tag, "_round"}, bus.out_round, rnd);
        chk({tag, "_last"},  bus.out_last,  rnd == 4'd10);
        chk({tag, "_err"},   bus.out_err,   (rnd == 4'd0) || (rnd > 4'd10));
    endtask

    // Ten back-to-back beats with out_ready high; results must follow in
    // order on consecutive cycles. errMode selects illegal round numbers.
    task automatic runBurst(input string tag, input bit errMode);
        logic [127:0] st [10];
        logic [127:0] ky [10];
        logic [3:0]   rd [10];
        int           j;
        int           r;
        for (int i = 0; i < 10; i++) begin
            st[i] = {$urandom, $urandom, $urandom, $urandom};
            ky[i] = {$urandom, $urandom, $urandom, $urandom};
            if (errMode) begin
                r = $urandom_range(10, 15);
                if (r == 10) r = 0;
                if (i == 0) r = 0;
                if (i == 1) r = 11;
            end else begin
                r = $urandom_range(1, 10);
                if (i == 9) r = 10;
            end
            rd[i] = 4'(r);
        end
        bus.out_ready = 1'b1;
        for (int n = 0; n < 10 + LAT; n++) begin
            if (n < 10) begin
                bus.in_valid = 1'b1;
                bus.in_state = st[n];
                bus.in_round = rd[n];
                bus.in_key   = ky[n];
                #1;
                chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
            end else begin
                bus.in_valid = 1'b0;
            end
            cyc();
            j = n + 1 - LAT;
            if (j >= 0 && j < 10)
                checkOutput($sformatf("%s_beat%0d", tag, j), refRound(st[j], rd[j], ky[j]), rd[j]);
            else
                chk({tag, "_idle_valid"}, bus.out_valid, 1'b0);
        end
    endtask

    initial begin
        logic [127:0] r1State, r1Key, r1Exp, rfState, rfKey, rfExp;
        logic [127:0] rs, rk;
        logic [3:0]   rr;
        bit           took;

        checks = 0;
        errors = 0;
        r1State = 128'hd42711aee0bf98f1b8b45de51e415230;
        r1Key   = 128'ha0fafe1788542cb123a339392a6c7605;
        r1Exp   = 128'ha49c7ff2689f352b6b5bea43026a5049;
        rfState = 128'he9098972cb31075f3d327d94af2e2cb5;
        rfKey   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        rfExp   = 128'h3925841d02dc09fbdc118597196a0b32;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.in_round  = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b1;
        $display("[TB] start, latency %0d", LAT);

        repeat (2) cyc();
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_state", bus.out_state, '0);
        chk("rst_round", bus.out_round, '0);
        chk("rst_last",  bus.out_last,  1'b0);
        chk("rst_err",   bus.out_err,   1'b0);
        chk("rst_ready", bus.in_ready,  1'b1);
        reset_n = 1'b1;
        cyc();

        // FIPS-197 round 1 with the consumer stalled.
        bus.out_ready = 1'b0;
        applyStimulus("fips_r1", r1State, 4'd1, r1Key, r1Exp);

        // Offer the final-round beat while stalled for five cycles.
        bus.in_valid = 1'b1;
        bus.in_state = rfState;
        bus.in_round = 4'd10;
        bus.in_key   = rfKey;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", k), bus.in_ready, (LAT == 2) && (k == 0));
            took = bus.in_valid && bus.in_ready;
            cyc();
            if (took) bus.in_valid = 1'b0;
            chk($sformatf("stall%0d_valid", k), bus.out_valid, 1'b1);
            chk($sformatf("stall%0d_state", k), bus.out_state, r1Exp);
            chk($sformatf("stall%0d_round", k), bus.out_round, 4'd1);
            chk($sformatf("stall%0d_last", k),  bus.out_last,  1'b0);
            chk($sformatf("stall%0d_err", k),   bus.out_err,   1'b0);
        end
        bus.out_ready = 1'b1;
        #1;
        took = bus.in_valid && bus.in_ready;
        cyc();
        if (took) bus.in_valid = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("fips_r10", rfExp, 4'd10);
        cyc();
        chk("drain_valid", bus.out_valid, 1'b0);

        runBurst("stream", 1'b0);
        runBurst("errs", 1'b1);

        // Reset while a result is held (and, pipelined, another is in flight).
        bus.out_ready = 1'b0;
        rs = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom};
        rr = 4'($urandom_range(1, 10));
        applyStimulus("pre_rst", rs, rr, rk, refRound(rs, rr, rk));
        bus.in_valid = 1'b1;
        bus.in_round = 4'd3;
        cyc();
        bus.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_state", bus.out_state, '0);
        chk("midrst_ready", bus.in_ready,  1'b1);
        repeat (2) cyc();
        @(negedge clk);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("post_rst%0d_valid", k), bus.out_valid, 1'b0);
        end
        rs = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom};
        rr = 4'($urandom_range(1, 10));
        applyStimulus("post_rst", rs, rr, rk, refRound(rs, rr, rk));
        cyc();
        chk("final_drain", bus.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
